// File: rtl/usb_dbg_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex helper for the USB
// debug path.
package usb_dbg_pkg;

    // Formatter states: one state per character kind, plus the guard cycle
    // that covers uart_tx's one-cycle lag before it raises busy, and the
    // wait for the character to finish shifting out.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_SEP,
        ST_CR,
        ST_LF,
        ST_GUARD,
        ST_WAIT
    } fmt_state_t;

    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] DIGIT0  = 8'h30;
    localparam logic [7:0] ALPHA_A = 8'h41;

    // Uppercase hex digit for one nibble: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return DIGIT0 + {4'h0, nibble};
        end
        return ALPHA_A + ({4'h0, nibble} - 8'd10);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small synchronous byte FIFO with occupancy counter. Pointers
// wrap naturally (DEPTH is a power of two); the level comes from its own
// counter so "full" and "empty" never need a pointer comparison.
module byte_fifo
    import usb_dbg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [7:0]             data_i,
    output logic [7:0]             data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             popDo;
    logic             pushDo;

    // A pop needs data; a push needs room, except that a pop in the same
    // cycle frees the slot, so a full FIFO still accepts when it is drained.
    always_comb begin
        popDo  = pop_i && (level_q != '0);
        pushDo = push_i && ((level_q != LVL_W'(DEPTH)) || popDo);
    end

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        level_d = level_q;
        if (pushDo && !popDo) begin
            level_d = level_q + LVL_W'(1);
        end else if (popDo && !pushDo) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage array; contents need no reset because the level gates reads.
    always_ff @(posedge clk_i) begin
        if (pushDo) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers and occupancy; reset discards whatever was queued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (pushDo) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (popDo) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/usb_hex_logger.sv
// usb_hex_logger: buffers bytes strobed out of the USB core and prints each
// one to uart_tx as two uppercase hex digits followed by a space, or by
// CR LF when the line is full, pacing characters on uart_tx's busy flag.
module usb_hex_logger
    import usb_dbg_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic                   clk48,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   uart_busy,
    output logic [7:0]             uart_d,
    output logic                   uart_dv,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

    logic [7:0] fifoHead;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       popReq;
    logic       overflow_d;

    fmt_state_t state_q;
    fmt_state_t nextState_q;
    logic [7:0] byte_q;
    logic [7:0] column_q;
    logic [7:0] uartChar_q;
    logic       uartDv_q;
    logic       overflow_q;

    // Character that a given send state puts on the wire.
    function automatic logic [7:0] charFor(input fmt_state_t st, input logic [7:0] b);
        case (st)
            ST_HI:   return hex_nibble_to_ascii(b[7:4]);
            ST_LO:   return hex_nibble_to_ascii(b[3:0]);
            ST_SEP:  return SPACE;
            ST_CR:   return CR;
            ST_LF:   return LF;
            default: return 8'h00;
        endcase
    endfunction

    // Take the next byte only when the formatter is idle and uart_tx is free.
    always_comb begin
        popReq = (state_q == ST_IDLE) && !fifoEmpty && !uart_busy;
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk48),
        .rst_i   (rst),
        .push_i  (in_valid),
        .pop_i   (popReq),
        .data_i  (in_data),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    // A byte is lost only when full and no pop frees a slot this cycle.
    always_comb begin
        overflow_d = overflow_q || (in_valid && fifoFull && !popReq);
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // Formatter: every send state is entered with uart_d/uart_dv already
    // loaded, so the strobe is registered and lasts exactly that one cycle;
    // GUARD and WAIT then hold off until uart_tx has finished the character.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nextState_q <= ST_IDLE;
            byte_q      <= 8'h00;
            column_q    <= 8'h00;
            uartChar_q  <= 8'h00;
            uartDv_q    <= 1'b0;
        end else begin
            uartDv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (popReq) begin
                        byte_q     <= fifoHead;
                        uartChar_q <= charFor(ST_HI, fifoHead);
                        uartDv_q   <= 1'b1;
                        state_q    <= ST_HI;
                    end
                end
                ST_HI: begin
                    nextState_q <= ST_LO;
                    state_q     <= ST_GUARD;
                end
                ST_LO: begin
                    if (column_q == LAST_COL) begin
                        nextState_q <= ST_CR;
                        column_q    <= 8'h00;
                    end else begin
                        nextState_q <= ST_SEP;
                        column_q    <= column_q + 8'd1;
                    end
                    state_q <= ST_GUARD;
                end
                ST_SEP: begin
                    nextState_q <= ST_IDLE;
                    state_q     <= ST_GUARD;
                end
                ST_CR: begin
                    nextState_q <= ST_LF;
                    state_q     <= ST_GUARD;
                end
                ST_LF: begin
                    nextState_q <= ST_IDLE;
                    state_q     <= ST_GUARD;
                end
                ST_GUARD: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!uart_busy) begin
                        state_q <= nextState_q;
                        if (nextState_q != ST_IDLE) begin
                            uartChar_q <= charFor(nextState_q, byte_q);
                            uartDv_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_d   = uartChar_q;
    assign uart_dv  = uartDv_q;
    assign overflow = overflow_q;

endmodule

// File: doc/usb_hex_logger.md
Name: usb_hex_logger

Overview:
Debug stage between the USB core's received-byte output and the uart_tx serializer. Captures each byte strobed out of the USB core into a small FIFO. Renders each byte as two uppercase ASCII hex digits plus a separator, and feeds the characters one at a time to uart_tx using its DV/busy handshake. Replaces the raw dout-to-UART path so USB traffic is human-readable on the debug serial port.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
BYTES_PER_LINE, 16, bytes printed per line before CR LF is emitted instead of a space; range 1..255.

Ports:
clk48  in  1  system clock, 48 MHz
rst  in  1  asynchronous active-high reset
in_data  in  8  byte from USB core (data_out)
in_valid  in  1  one-cycle strobe; in_data is valid in that cycle
uart_busy  in  1  o_TX_Active from uart_tx
uart_d  out  8  ASCII character to uart_tx i_TX_Byte
uart_dv  out  1  one-cycle send pulse to uart_tx i_TX_DV
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async assert, synchronous-safe release): FIFO empty, fifo_level=0, overflow=0, uart_dv=0, uart_d=8'h00, column counter=0, FSM=IDLE.
- FIFO write: on in_valid with level<DEPTH, push in_data; level increments next cycle.
- FIFO full: on in_valid with level==DEPTH, drop the byte and set overflow=1. It stays set until rst.
- Simultaneous push and pop in the same cycle: both occur and level is unchanged. A push when full that coincides with a pop is accepted (no drop).
- Pointers are log2(DEPTH) bits and wrap naturally. level is computed from a separate counter, not from a pointer difference.
- FSM states: IDLE, HI, LO, SEP, CR, LF, GUARD, WAIT.
- IDLE: if FIFO non-empty and uart_busy==0, pop the head into a byte register and go to HI.
- HI: uart_d=hex(byte[7:4]), uart_dv=1 for exactly 1 cycle. Record next=LO. Go to GUARD.
- LO: send hex(byte[3:0]). Then, if column==BYTES_PER_LINE-1, set next=CR and column=0; otherwise set next=SEP and increment column.
- SEP: send 8'h20 (space); next=IDLE.
- CR: send 8'h0D; next=LF.
- LF: send 8'h0A; next=IDLE.
- GUARD: one cycle in which uart_busy is ignored (uart_tx asserts Active one cycle after DV). Then go to WAIT.
- WAIT: stay while uart_busy==1. When uart_busy==0, go to the recorded next state.
- Hex encoding: 0-9 map to 8'h30-8'h39; A-F map to 8'h41-8'h46 (uppercase).
- uart_dv is never high in two consecutive cycles. uart_dv is never asserted while uart_busy==1.
- uart_d holds its value until the next send.
- Latency: with the FIFO empty, the FSM in IDLE and the UART idle, in_valid at cycle N gives the pop at N+1, HI entered at N+2, and uart_dv high at N+2.
- Each byte costs 3 UART characters, or 4 at end of line. Sustained input faster than that rate fills the FIFO and sets overflow. The formatter is unaffected and keeps draining.
- Reset mid-character: the FSM returns to IDLE immediately and the FIFO contents are discarded. uart_tx is not reset by this block. After reset, the FSM waits for uart_busy==0 before the next send.

Decomposition:
- Package usb_dbg_pkg:
  - FSM state enum.
  - ASCII constants: SPACE=8'h20, CR=8'h0D, LF=8'h0A, DIGIT0=8'h30, ALPHA_A=8'h41.
  - hex_nibble_to_ascii function.
- Sub-module byte_fifo (DEPTH parameter): push/pop/full/empty/level and registered storage. It is reused later for the USB TX path.
- The formatter FSM stays in usb_hex_logger.

Test Plan:
- Reset release, no input -> uart_dv stays 0 for 1000 cycles; fifo_level=0; overflow=0.
- Single byte 8'hA5 on an idle UART (bench uart_tx model, 416 clks/bit) -> characters 8'h41, 8'h35, 8'h20 in order; uart_dv pulses exactly 3 times; no pulse while busy=1.
- 16 bytes 8'h00..8'h0F streamed one every 2000 cycles -> "00 01 … 0E 0F" then 8'h0D, 8'h0A after 0F, with no space before CR. Byte 17 restarts at column 0.
- 20-byte burst in consecutive cycles, DEPTH=16 -> fifo_level reaches 16; overflow=1 at the 17th write (or later, given one pop); all accepted bytes print in order with none duplicated.
- Push and pop in the same cycle at level==DEPTH -> level stays DEPTH; no overflow.
- rst asserted during WAIT with 5 bytes queued -> next cycle fifo_level=0, state IDLE, uart_dv=0. The first post-reset send occurs only after uart_busy falls.
